// File: rtl/rvcpu.sv
// Shared CPU pipeline definitions: depth limits, counters and stage payload structs.
package rvcpu;

    // Largest buffer depth any pipeline stage may be built with.
    localparam int unsigned PIPE_DEPTH_MAX = 4;

    // Wide enough to hold any occupancy count up to PIPE_DEPTH_MAX.
    typedef logic [2:0] pipe_cnt_t;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    // Fetch -> decode payload.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } stage_if_t;

    // Decode -> execute payload.
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rd;
        alu_op_e          alu_op;
        mem_op_e          mem_op;
    } stage_id_t;

    // Execute -> memory payload.
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  alu_res;
        logic [XLEN-1:0]  rs2_val;
        logic [REG_W-1:0] rd;
        mem_op_e          mem_op;
    } stage_ex_t;

    // Memory -> writeback payload.
    typedef struct packed {
        logic [XLEN-1:0]  wb_data;
        logic [REG_W-1:0] rd;
        logic             wb_en;
    } stage_mem_t;

    // Pointer width for a modulo-n counter; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrap_ctr.sv
// Modulo-MOD pointer with increment and synchronous clear; wraps MOD-1 -> 0.
module wrap_ctr
    import rvcpu::*;
#(
    parameter  int unsigned MOD = 2,
    localparam int unsigned W   = ptr_width(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Pointer register: reset/clear to zero, otherwise step and wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == W'(MOD - 1)) ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline buffer: DEPTH-entry FIFO with valid/ready on both sides,
// one-cycle latency, flush kill and synchronous reset.
// Optional build macro PIPE_STAGE_PERF_EN adds the stall_cycles counter port.
module pipe_stage
    import rvcpu::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    // Handshakes depend only on registered occupancy and flush.
    assign in_ready  = (count != CNT_W'(DEPTH)) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head entry, forced to zero while empty so stale storage never leaks.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Occupancy next-state: flush clears, otherwise push/pop net out.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Payload storage; occupancy alone decides validity so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    wrap_ctr #(.MOD(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .inc   (push),
        .value (wr_ptr)
    );

    wrap_ctr #(.MOD(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .inc   (pop),
        .value (rd_ptr)
    );

`ifdef PIPE_STAGE_PERF_EN
    // Saturating count of cycles where the head is held back by downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Randomized and directed bench for pipe_stage, DEPTH=2 and DEPTH=3 instances
// sharing one input stream, checked against queue-based reference models.
module tb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready2, out_valid2, in_ready3, out_valid3;
    logic [31:0] out_data2, out_data3;
    logic [1:0]  count2, count3;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall2, stall3;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] q2[$];
    logic [31:0] q3[$];
    logic [31:0] m_stall2, m_stall3;

    always #5 clk = ~clk;

    pipe_stage #(.WIDTH(32), .DEPTH(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_data   (in_data),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_data  (out_data2),
        .count     (count2)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cycles (stall2)
`endif
    );

    pipe_stage #(.WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .in_data   (in_data),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_data  (out_data3),
        .count     (count3)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cycles (stall3)
`endif
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every observable output of both instances with the models.
    task automatic check_outputs();
        chk_eq("d2.out_valid", 32'(out_valid2), 32'(q2.size() != 0));
        chk_eq("d2.out_data",  out_data2, (q2.size() != 0) ? q2[0] : 32'h0);
        chk_eq("d2.count",     32'(count2), 32'(q2.size()));
        chk_eq("d2.in_ready",  32'(in_ready2), 32'((q2.size() < 2) && !flush));
        chk_eq("d3.out_valid", 32'(out_valid3), 32'(q3.size() != 0));
        chk_eq("d3.out_data",  out_data3, (q3.size() != 0) ? q3[0] : 32'h0);
        chk_eq("d3.count",     32'(count3), 32'(q3.size()));
        chk_eq("d3.in_ready",  32'(in_ready3), 32'((q3.size() < 3) && !flush));
`ifdef PIPE_STAGE_PERF_EN
        chk_eq("d2.stall", stall2, m_stall2);
        chk_eq("d3.stall", stall3, m_stall3);
`endif
    endtask

    // Drive one cycle's inputs mid-cycle, then check outputs.
    task automatic apply(input logic r, input logic f, input logic iv,
                         input logic [31:0] d, input logic ordy);
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        check_outputs();
    endtask

    // Advance the models by the rules for this cycle, then take the clock edge.
    task automatic step();
        if (rst) begin
            q2.delete();
            q3.delete();
            m_stall2 = 32'h0;
            m_stall3 = 32'h0;
        end else begin
            if (q2.size() != 0 && !out_ready && !flush && m_stall2 != 32'hFFFF_FFFF) m_stall2++;
            if (q3.size() != 0 && !out_ready && !flush && m_stall3 != 32'hFFFF_FFFF) m_stall3++;
            if (flush) begin
                q2.delete();
                q3.delete();
            end else begin
                logic push2, push3;
                push2 = in_valid && (q2.size() < 2);
                push3 = in_valid && (q3.size() < 3);
                if (q2.size() != 0 && out_ready) void'(q2.pop_front());
                if (q3.size() != 0 && out_ready) void'(q3.pop_front());
                if (push2) q2.push_back(in_data);
                if (push3) q3.push_back(in_data);
            end
        end
        @(posedge clk);
    endtask

    initial begin
        int unsigned exp_next;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_stall2 = '0; m_stall3 = '0;
        repeat (2) @(posedge clk);

        // Reset state, held with flush low.
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_eq("rst.in_ready", 32'(in_ready2), 32'd1);
        chk_eq("rst.count", 32'(count2), 32'd0);
        chk_eq("rst.out_data", out_data2, 32'h0);

        // Single push with 1-cycle latency then drain.
        step();
        apply(1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b1);
        step();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_eq("lat.out_valid", 32'(out_valid2), 32'd1);
        chk_eq("lat.out_data", out_data2, 32'h0000_0013);
        step();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_eq("lat.count", 32'(count2), 32'd0);
        step();

        // Fill DEPTH=2 with downstream blocked, then drain in order.
        apply(1'b0, 1'b0, 1'b1, 32'hA, 1'b0); step();
        apply(1'b0, 1'b0, 1'b1, 32'hB, 1'b0); step();
        apply(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
        chk_eq("full.count", 32'(count2), 32'd2);
        chk_eq("full.in_ready", 32'(in_ready2), 32'd0);
        chk_eq("full.head", out_data2, 32'hA);
        step();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_eq("drain.second", out_data2, 32'hB);
        step();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); step();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); step();

        // Flush while full with a competing push.
        apply(1'b0, 1'b0, 1'b1, 32'h11, 1'b0); step();
        apply(1'b0, 1'b0, 1'b1, 32'h22, 1'b0); step();
        apply(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b1); step();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_eq("flush.count", 32'(count2), 32'd0);
        chk_eq("flush.out_valid", 32'(out_valid2), 32'd0);
        step();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_eq("flush.no_leak", out_data2, 32'h0);
        step();
        // Flush while empty only lowers in_ready.
        apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk_eq("flush_empty.in_ready", 32'(in_ready3), 32'd0);
        step();

        // DEPTH=3 streaming 1..10 with continuous pop: order and wrap.
        exp_next = 1;
        for (int i = 1; i <= 12; i++) begin
            apply(1'b0, 1'b0, (i <= 10), 32'(i), 1'b1);
            if (out_valid3) begin
                chk_eq("wrap.order", out_data3, 32'(exp_next));
                exp_next++;
            end
            step();
        end
        chk_eq("wrap.delivered", 32'(exp_next), 32'd11);

        // Stall counter: one entry held, downstream blocked 5 cycles, then reset.
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); step();
        apply(1'b0, 1'b0, 1'b1, 32'h55, 1'b0); step();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); step();
        end
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        chk_eq("perf.stall5", stall2, 32'd5);
`endif
        chk_eq("perf.held", 32'(count2), 32'd1);
        step();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_eq("perf.rst_count", 32'(count2), 32'd0);
`ifdef PIPE_STAGE_PERF_EN
        chk_eq("perf.rst_stall", stall2, 32'd0);
`endif
        step();

        // Randomized traffic with varying downstream pressure.
        for (int blk = 0; blk < 4; blk++) begin
            for (int c = 0; c < 150; c++) begin
                apply($urandom_range(0, 199) == 0,
                      $urandom_range(0, 19) == 0,
                      $urandom_range(0, 99) < 65,
                      $urandom,
                      $urandom_range(0, 99) < (15 + blk * 25));
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
